flit_arb_mux: RTL

- N-input, FLIT_WIDTH-bit flit multiplexer with round-robin arbitration, wormhole packet locking and a one-entry registered output stage.
- Generalised, sequential successor to the fixed 2:1 x40 flit mux.
- Sits at each router output port, selecting among input-port flit streams and presenting one stream to the link/output buffer.

---
 rtl/flit_arb_mux.sv | 108 ++++++++++
 1 files changed

// File: rtl/flit_arb_mux.sv
// N-input round-robin flit multiplexer with wormhole packet locking and a
// single registered output stage feeding the link/output buffer.
module flit_arb_mux #(
   parameter int N_INPUTS   = 4,
   parameter int FLIT_WIDTH = 40,
   parameter int PTR_W      = $clog2(N_INPUTS)
) (
   input  logic                           clk,
   input  logic                           reset,
   input  logic [N_INPUTS-1:0]            in_valid,
   input  logic [N_INPUTS*FLIT_WIDTH-1:0] in_flit,
   input  logic [N_INPUTS-1:0]            in_tail,
   output logic [N_INPUTS-1:0]            in_ack,
   output logic                           out_valid,
   output logic [FLIT_WIDTH-1:0]          out_flit,
   output logic                           out_tail,
   input  logic                           out_ready
);

   // state  | meaning
   // IDLE   | no packet in flight; round-robin search from rr_ptr each cycle
   // LOCKED | mid-packet; only owner may transfer until its tail is acked
   typedef enum logic {IDLE, LOCKED} state_t;

   state_t               state, state_nxt;
   logic [PTR_W-1:0]     rr_ptr, rr_ptr_nxt;
   logic [PTR_W-1:0]     owner, owner_nxt;
   logic [PTR_W-1:0]     win, sel;
   logic                 win_found;
   logic [PTR_W:0]       idx_w;
   logic                 space, req, grant;
   logic [FLIT_WIDTH-1:0] sel_flit;
   logic                 sel_tail;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      if (p == PTR_W'(N_INPUTS - 1)) return '0;
      return p + 1'b1;
   endfunction

   // Wrap-around search for the first requester at or above rr_ptr.
   always_comb begin
      win       = '0;
      win_found = 1'b0;
      idx_w     = '0;
      for (int k = 0; k < N_INPUTS; k++) begin
         idx_w = {1'b0, rr_ptr} + (PTR_W+1)'(k);
         if (idx_w >= (PTR_W+1)'(N_INPUTS)) idx_w = idx_w - (PTR_W+1)'(N_INPUTS);
         if (!win_found && in_valid[idx_w[PTR_W-1:0]]) begin
            win       = idx_w[PTR_W-1:0];
            win_found = 1'b1;
         end
      end
   end

   // Grant path looks only at valids and output occupancy, never at flit data.
   always_comb begin
      space    = !out_valid || out_ready;
      sel      = (state == LOCKED) ? owner : win;
      req      = (state == LOCKED) ? in_valid[owner] : win_found;
      grant    = req && space && !reset;
      in_ack   = '0;
      if (grant) in_ack[sel] = 1'b1;
      sel_flit = in_flit[sel*FLIT_WIDTH +: FLIT_WIDTH];
      sel_tail = in_tail[sel];
   end

   always_comb begin
      state_nxt  = state;
      rr_ptr_nxt = rr_ptr;
      owner_nxt  = owner;
      if (grant) begin
         if (sel_tail) begin
            state_nxt  = IDLE;
            rr_ptr_nxt = ptr_inc(sel);
         end else if (state == IDLE) begin
            state_nxt = LOCKED;
            owner_nxt = win;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state  <= IDLE;
         rr_ptr <= '0;
         owner  <= '0;
      end else begin
         state  <= state_nxt;
         rr_ptr <= rr_ptr_nxt;
         owner  <= owner_nxt;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         out_valid <= 1'b0;
         out_flit  <= '0;
         out_tail  <= 1'b0;
      end else if (grant) begin
         out_valid <= 1'b1;
         out_flit  <= sel_flit;
         out_tail  <= sel_tail;
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
   end

endmodule
